inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage that produces the `if_pc`/`if_inst` pair consumed by the IF/ID pipeline register. It owns the program counter, runs a req/ack handshake to instruction memory, absorbs one instruction while the pipeline is stalled, and discards in-flight fetches on a branch/jump redirect. When it has no valid instruction it presents a zero instruction, which matches the IF/ID flush value.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-low.
- `if_stall` in 1: hazard stall. Hold the outputs; same signal as drives `if_id_stall`.
- `redirect` in 1: branch/jump taken. Flush fetch and restart at `redirect_pc`.
- `redirect_pc` in 32: new fetch address; bits [1:0] forced to 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; stable while `imem_req` is high and no ack has arrived.
- `imem_ack` in 1: response strobe; `imem_rdata` is valid in the same cycle. Zero-wait memory may ack in the same cycle as the request.
- `imem_rdata` in 32: instruction word.
- `if_pc` out 32: PC of the presented instruction.
- `if_inst` out 32: presented instruction; 0 when `if_valid` is 0.
- `if_valid` out 1: `if_pc`/`if_inst` hold a real instruction.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_addr`: address of the outstanding request.
  - Output regs.
  - One-entry pending buffer: `pend_pc`, `pend_inst`, `pend_valid`.
  - State.
- States:
  - RUN: no request outstanding.
  - WAIT: request outstanding.
  - DISCARD: outstanding request whose data must be dropped.
- RUN:
  - `imem_req = rst & !redirect & !pend_valid`; `imem_addr = pc`.
  - On issue: `req_addr <= pc`, `pc <= pc + 4` (32-bit wrap, FFFF_FFFC -> 0).
  - Issue with no ack -> WAIT.
- WAIT:
  - `imem_req = 1`; `imem_addr = req_addr`.
  - Ack -> RUN.
- DISCARD:
  - Same drive as WAIT.
  - Ack: data dropped -> RUN.
- Capture, on a non-discarded ack at the edge:
  - `if_stall` = 0: `if_pc <= imem_addr`, `if_inst <= imem_rdata`, `if_valid <= 1`.
  - `if_stall` = 1: the data goes to the pending buffer and `pend_valid <= 1`. Outputs are held.
- Output update when there is no redirect:
  - `if_stall` = 1: outputs hold.
  - Else `pend_valid` = 1: outputs <= pending entry, `pend_valid <= 0`. No request is issued this cycle.
  - Else ack captured: outputs <= fetched data.
  - Else: bubble, `if_pc <= 0`, `if_inst <= 0`, `if_valid <= 0`.
- Redirect has highest priority and overrides stall:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - Outputs cleared to 0.
  - `pend_valid <= 0`.
  - Any same-cycle ack data is dropped.
  - Next state:
    - WAIT without ack -> DISCARD.
    - WAIT with ack -> RUN.
    - DISCARD without ack stays DISCARD with the new `pc`.
    - DISCARD with ack -> RUN.
    - RUN stays RUN.
- No `imem_req` is issued in the redirect cycle.
- At most one request is outstanding; at most one instruction is buffered.

## Timing
- Reset (`rst` = 0 at an edge):
  - `pc = RESET_PC`, state RUN, `pend_valid = 0`.
  - `if_pc = 0`, `if_inst = 0`, `if_valid = 0`.
  - `imem_req = 0` while `rst` is low.
- Reset mid-transaction abandons the outstanding request. Memory must tolerate this; a late ack in RUN is ignored.
- Latency: ack at edge N -> `if_valid` = 1 after edge N -> IF/ID latches it at edge N+1.
- Zero-wait memory gives one instruction per cycle and no bubbles.
- K wait cycles give K bubble cycles per instruction.
- Redirect at edge N: first request to the target goes out in cycle N+1, or after the discarded ack when in DISCARD.
- Stall release: the buffered instruction appears the cycle after `if_stall` falls. The next request issues one cycle later.

## Test plan
- Reset with `RESET_PC` = 32'h100 and a zero-wait memory returning `mem[a] = a ^ 32'hA5A5_0000`:
  - All outputs are 0 during reset.
  - After release: `if_pc` = 100, 104, 108 on consecutive cycles with matching `if_inst`, `if_valid` held at 1.
- Memory acks 2 cycles after the request:
  - `imem_addr` stays stable while waiting.
  - `if_valid` pattern is 1,0,0,1,0,0; `if_inst` = 0 in bubble cycles.
- `if_stall` for 3 cycles while a request is outstanding for 0x10C:
  - `if_pc` is held at 0x108.
  - 0x10C is buffered and no further request is issued.
  - 0x10C appears the cycle after the stall releases, followed by 0x110.
- Redirect to 0x203 while in WAIT on 0x110, with the ack 2 cycles later:
  - The 0x110 data never appears; outputs are 0 in the meantime.
  - Next `imem_addr` = 0x200 and `if_pc` = 0x200.
- Redirect and `if_stall` asserted together while a pending entry is held:
  - Outputs and the pending entry are cleared; fetch restarts at the target.
- Redirect to 0xFFFF_FFFC with zero-wait memory:
  - `if_pc` sequence is FFFF_FFFC, 0000_0000, 0000_0004.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, buffers one
// instruction across a stall and drops in-flight fetches on a redirect.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_req_addr;
  logic [XLEN-1:0]   r_pend_pc;
  logic [XLEN-1:0]   r_pend_inst;
  logic              r_pend_valid;
  logic [XLEN-1:0]   r_if_pc;
  logic [XLEN-1:0]   r_if_inst;
  logic              r_if_valid;

  logic              w_issue;
  logic              w_ack_take;
  logic [XLEN-1:0]   w_redirect_tgt;

  // A new request leaves only from RUN; acks count only for a live, non-discarded request
  assign w_issue        = (r_state == S_RUN) && imem_req;
  assign w_ack_take     = imem_ack && !redirect && (w_issue || (r_state == S_WAIT));
  assign w_redirect_tgt = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_issue && !imem_ack) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack)      w_state_nxt = S_RUN;
        else if (redirect) w_state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        if (imem_ack) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Memory-side drive; the outstanding address is held until its ack
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    case (r_state)
      S_RUN: begin
        imem_req = rst && !redirect && !r_pend_valid;
      end
      S_WAIT, S_DISCARD: begin
        imem_req  = rst;
        imem_addr = r_req_addr;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_req_addr   <= '0;
      r_pend_pc    <= '0;
      r_pend_inst  <= '0;
      r_pend_valid <= 1'b0;
      r_if_pc      <= '0;
      r_if_inst    <= '0;
      r_if_valid   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_req_addr <= r_pc;
        r_pc       <= r_pc + XLEN'(4);
      end
      if (redirect) begin
        r_pc         <= w_redirect_tgt;
        r_pend_valid <= 1'b0;
        r_if_pc      <= '0;
        r_if_inst    <= '0;
        r_if_valid   <= 1'b0;
      end else if (if_stall) begin
        if (w_ack_take) begin
          r_pend_pc    <= imem_addr;
          r_pend_inst  <= imem_rdata;
          r_pend_valid <= 1'b1;
        end
      end else if (r_pend_valid) begin
        r_if_pc      <= r_pend_pc;
        r_if_inst    <= r_pend_inst;
        r_if_valid   <= 1'b1;
        r_pend_valid <= 1'b0;
      end else if (w_ack_take) begin
        r_if_pc    <= imem_addr;
        r_if_inst  <= imem_rdata;
        r_if_valid <= 1'b1;
      end else begin
        r_if_pc    <= '0;
        r_if_inst  <= '0;
        r_if_valid <= 1'b0;
      end
    end
  end

  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;
  assign if_valid = r_if_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random stall/redirect/latency traffic
// against a transaction-level model of the fetch stage and a variable-latency memory.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_stall   (if_stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_valid   (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Reference model: fetch stage as "one transaction in flight" plus a FIFO of depth one
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  bit          m_busy;
  bit          m_drop;
  ent_t        m_pend[$];
  logic [31:0] m_out_pc;
  logic [31:0] m_out_inst;
  bit          m_out_v;

  // Memory model state
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          fixed_lat;

  task automatic model_step(input bit rst_v, input bit stall_v, input bit redir_v,
                            input logic [31:0] rpc, input bit ack, input bit req);
    bit          issue;
    bit          live_ack;
    bit          data_ok;
    logic [31:0] cap_addr;
    if (!rst_v) begin
      m_pc = RST_PC; m_req_addr = '0; m_busy = 0; m_drop = 0;
      m_pend.delete();
      m_out_pc = '0; m_out_inst = '0; m_out_v = 0;
      return;
    end
    issue    = !m_busy && req;
    live_ack = ack && (m_busy || issue);
    cap_addr = issue ? m_pc : m_req_addr;
    data_ok  = live_ack && !m_drop && !redir_v;
    if (issue) begin
      m_req_addr = m_pc;
      m_pc       = m_pc + 32'd4;
    end
    if (m_busy || issue) m_busy = !live_ack;
    if (redir_v) begin
      m_pc   = {rpc[31:2], 2'b00};
      m_drop = m_busy;
      m_pend.delete();
      m_out_pc = '0; m_out_inst = '0; m_out_v = 0;
    end else begin
      if (!m_busy) m_drop = 0;
      if (stall_v) begin
        if (data_ok) m_pend.push_back('{pc: cap_addr, inst: mem_word(cap_addr)});
      end else if (m_pend.size() != 0) begin
        ent_t e;
        e = m_pend.pop_front();
        m_out_pc = e.pc; m_out_inst = e.inst; m_out_v = 1;
      end else if (data_ok) begin
        m_out_pc = cap_addr; m_out_inst = mem_word(cap_addr); m_out_v = 1;
      end else begin
        m_out_pc = '0; m_out_inst = '0; m_out_v = 0;
      end
    end
  endtask

  // One clock cycle: drive inputs, answer the request, predict, then check after the edge
  task automatic cycle(input bit rst_v, input bit stall_v, input bit redir_v,
                       input logic [31:0] rpc);
    bit          exp_req;
    logic [31:0] exp_addr;
    int          lat;
    rst = rst_v; if_stall = stall_v; redirect = redir_v; redirect_pc = rpc;
    #1;
    if (!rst_v)      exp_req = 0;
    else if (m_busy) exp_req = 1;
    else             exp_req = !redir_v && (m_pend.size() == 0);
    exp_addr = m_busy ? m_req_addr : m_pc;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_addr);

    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    lat = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
    if (!rst_v) begin
      mem_busy = 0;
    end else if (mem_busy) begin
      check("addr_hold", imem_addr, mem_addr);
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_ack = 1'b1; imem_rdata = mem_word(mem_addr); mem_busy = 0;
      end
    end else if (imem_req) begin
      mem_addr = imem_addr;
      mem_cnt  = lat;
      if (lat == 0) begin
        imem_ack = 1'b1; imem_rdata = mem_word(mem_addr);
      end else begin
        mem_busy = 1;
      end
    end
    model_step(rst_v, stall_v, redir_v, rpc, imem_ack, exp_req);

    @(posedge clk);
    #1;
    check("if_valid", 32'(if_valid), 32'(m_out_v));
    check("if_pc", if_pc, m_out_pc);
    check("if_inst", if_inst, m_out_inst);
  endtask

  initial begin
    rst = 1'b0; if_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    mem_busy = 0; mem_cnt = 0; mem_addr = '0;
    fixed_lat = 0;
    model_step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Reset: everything zero
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_inst", if_inst, 32'd0);

    // Zero-wait streaming from RESET_PC
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("first_pc", if_pc, 32'h100);
    check("first_inst", if_inst, 32'hA5A5_0100);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, '0);

    // Two wait cycles per fetch
    fixed_lat = 2;
    repeat (9) cycle(1'b1, 1'b0, 1'b0, '0);

    // Stall while a fetch is outstanding
    fixed_lat = 1;
    cycle(1'b1, 1'b0, 1'b0, '0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, '0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, '0);

    // Redirect while waiting; the in-flight data must be dropped
    fixed_lat = 2;
    repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 32'h203);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, '0);

    // Redirect together with stall while an entry is buffered
    fixed_lat = 0;
    repeat (2) cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 32'h300);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, '0);

    // PC wrap past the top of the address space
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("wrap_pc0", if_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("wrap_pc1", if_pc, 32'h0000_0000);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("wrap_pc2", if_pc, 32'h0000_0004);

    // Random traffic: latency 0..3, stalls, redirects, occasional reset
    fixed_lat = -1;
    for (int i = 0; i < 800; i++) begin
      bit          r_v;
      bit          s_v;
      bit          d_v;
      logic [31:0] tgt;
      r_v = ($urandom_range(0, 99) != 0);
      s_v = ($urandom_range(0, 3) == 0);
      d_v = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 1) == 0) ? 32'($urandom)
                                        : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      cycle(r_v, s_v, d_v, tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
